// File: rtl/lfo_param_control.sv
// rtl/lfo_param_control.sv - two-encoder LFO parameter control (shape/depth/freq); FREQ_ACCEL_EN enables fast-turn freq steps
module lfo_param_control #(
    parameter int DEBOUNCE_CYC = 100,
    parameter int NUM_SHAPES   = 4,
    parameter int MAX_DEPTH    = 7,
    parameter int MIN_BPM      = 20,
    parameter int MAX_BPM      = 240,
    parameter int FREQ_STEP    = 1,
    parameter int ACCEL_WINDOW = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc1_a,
    input  logic       enc1_b,
    input  logic       enc2_a,
    input  logic       enc2_b,
    output logic [2:0] shape,
    output logic [2:0] depth,
    output logic [7:0] freq,
    output logic [1:0] sel,
    output logic       param_upd
);

    localparam int DBW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [8:0] MIN9 = 9'(MIN_BPM);
    localparam logic [8:0] MAX9 = 9'(MAX_BPM);

    typedef enum logic [1:0] {
        SEL_SHAPE = 2'd0,
        SEL_DEPTH = 2'd1,
        SEL_FREQ  = 2'd2
    } sel_t;

    // Pin order: {enc1_a, enc1_b, enc2_a, enc2_b}
    logic [3:0]     pin_raw;
    logic [3:0]     sync1;
    logic [3:0]     sync2;
    logic [3:0]     cand;
    logic [3:0]     db;
    logic [3:0]     db_valid;
    logic [DBW-1:0] db_cnt [4];

    assign pin_raw = {enc1_a, enc1_b, enc2_a, enc2_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            cand     <= '0;
            db       <= '0;
            db_valid <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= pin_raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] != cand[i]) begin
                    cand[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] != DBW'(DEBOUNCE_CYC - 1)) begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end else begin
                    db[i]       <= cand[i];
                    db_valid[i] <= 1'b1;
                end
            end
        end
    end

    // Index 0 = enc1 (field select), index 1 = enc2 (adjust)
    logic [1:0] enc_ab    [2];
    logic [1:0] prev_ab   [2];
    logic [2:0] sub_cnt   [2];
    logic [1:0] gray_dir  [2];
    logic [3:0] sub_sum   [2];
    logic [1:0] enc_valid;
    logic [1:0] primed;
    logic [1:0] step_up;
    logic [1:0] step_dn;

    assign enc_ab[0]    = db[3:2];
    assign enc_ab[1]    = db[1:0];
    assign enc_valid[0] = db_valid[3] & db_valid[2];
    assign enc_valid[1] = db_valid[1] & db_valid[0];

    function automatic logic [1:0] quad_dir(input logic [1:0] p, input logic [1:0] n);
        case ({p, n})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: quad_dir = 2'b01;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: quad_dir = 2'b11;
            default:                            quad_dir = 2'b00;
        endcase
    endfunction

    always_comb begin
        for (int e = 0; e < 2; e++) begin
            gray_dir[e] = quad_dir(prev_ab[e], enc_ab[e]);
            sub_sum[e]  = {sub_cnt[e][2], sub_cnt[e]} + {{2{gray_dir[e][1]}}, gray_dir[e]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed  <= '0;
            step_up <= '0;
            step_dn <= '0;
            for (int e = 0; e < 2; e++) begin
                prev_ab[e] <= '0;
                sub_cnt[e] <= '0;
            end
        end else begin
            for (int e = 0; e < 2; e++) begin
                step_up[e] <= 1'b0;
                step_dn[e] <= 1'b0;
                if (!primed[e]) begin
                    // Wait for the first accepted sample so stale reset values never count
                    if (enc_valid[e]) begin
                        prev_ab[e] <= enc_ab[e];
                        primed[e]  <= 1'b1;
                    end
                end else begin
                    prev_ab[e] <= enc_ab[e];
                    if (sub_sum[e] == 4'b0100) begin
                        step_up[e] <= 1'b1;
                        sub_cnt[e] <= '0;
                    end else if (sub_sum[e] == 4'b1100) begin
                        step_dn[e] <= 1'b1;
                        sub_cnt[e] <= '0;
                    end else begin
                        sub_cnt[e] <= sub_sum[e][2:0];
                    end
                end
            end
        end
    end

    sel_t state;
    sel_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SEL_FREQ;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (step_up[0]) begin
            case (state)
                SEL_SHAPE: state_nxt = SEL_DEPTH;
                SEL_DEPTH: state_nxt = SEL_FREQ;
                default:   state_nxt = SEL_SHAPE;
            endcase
        end else if (step_dn[0]) begin
            case (state)
                SEL_SHAPE: state_nxt = SEL_FREQ;
                SEL_DEPTH: state_nxt = SEL_SHAPE;
                default:   state_nxt = SEL_DEPTH;
            endcase
        end
    end

    assign sel = state;

    logic [8:0] freq_step9;

`ifdef FREQ_ACCEL_EN
    localparam int ACW = $clog2(ACCEL_WINDOW + 1);
    logic [ACW-1:0] accel_cnt;

    // Saturated count means "no recent detent"; a field change forces that state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accel_cnt <= ACW'(ACCEL_WINDOW);
        end else if (state_nxt != state) begin
            accel_cnt <= ACW'(ACCEL_WINDOW);
        end else if (step_up[1] || step_dn[1]) begin
            accel_cnt <= '0;
        end else if (accel_cnt != ACW'(ACCEL_WINDOW)) begin
            accel_cnt <= accel_cnt + 1'b1;
        end
    end

    assign freq_step9 = (accel_cnt < ACW'(ACCEL_WINDOW)) ? 9'(4 * FREQ_STEP) : 9'(FREQ_STEP);
`else
    assign freq_step9 = 9'(FREQ_STEP);
`endif

    logic [2:0] shape_nxt;
    logic [2:0] depth_nxt;
    logic [7:0] freq_nxt;
    logic [8:0] freq_up9;

    // Adjust uses the field registered before this cycle, even if sel moves now
    always_comb begin
        shape_nxt = shape;
        depth_nxt = depth;
        freq_nxt  = freq;
        freq_up9  = {1'b0, freq} + freq_step9;
        if (step_up[1] || step_dn[1]) begin
            case (state)
                SEL_SHAPE: begin
                    if (step_up[1])
                        shape_nxt = (shape == 3'(NUM_SHAPES - 1)) ? 3'd0 : shape + 3'd1;
                    else
                        shape_nxt = (shape == 3'd0) ? 3'(NUM_SHAPES - 1) : shape - 3'd1;
                end
                SEL_DEPTH: begin
                    if (step_up[1])
                        depth_nxt = (depth == 3'(MAX_DEPTH)) ? depth : depth + 3'd1;
                    else
                        depth_nxt = (depth == 3'd0) ? depth : depth - 3'd1;
                end
                SEL_FREQ: begin
                    if (step_up[1])
                        freq_nxt = (freq_up9 > MAX9) ? MAX9[7:0] : freq_up9[7:0];
                    else
                        freq_nxt = ({1'b0, freq} < MIN9 + freq_step9) ? MIN9[7:0]
                                                                      : freq - freq_step9[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shape     <= 3'd1;
            depth     <= 3'd3;
            freq      <= 8'd100;
            param_upd <= 1'b0;
        end else begin
            shape     <= shape_nxt;
            depth     <= depth_nxt;
            freq      <= freq_nxt;
            param_upd <= (shape_nxt != shape) || (depth_nxt != depth) ||
                         (freq_nxt != freq) || (state_nxt != state);
        end
    end

endmodule

// File: tb/tb_lfo_param_control.sv
// tb/tb_lfo_param_control.sv - randomized self-checking bench for lfo_param_control
module tb_lfo_param_control;

    localparam int DB           = 30;
    localparam int HOLD         = DB + 30;
    localparam int NUM_SHAPES   = 4;
    localparam int MAX_DEPTH    = 7;
    localparam int MIN_BPM      = 20;
    localparam int MAX_BPM      = 240;
    localparam int FREQ_STEP    = 1;
    localparam int ACCEL_WINDOW = 2000;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       enc1_a = 1'b1;
    logic       enc1_b = 1'b1;
    logic       enc2_a = 1'b1;
    logic       enc2_b = 1'b1;
    logic [2:0] shape;
    logic [2:0] depth;
    logic [7:0] freq;
    logic [1:0] sel;
    logic       param_upd;
    logic [15:0] act_vec;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int upd_cnt = 0;

    int m_shape, m_depth, m_freq, m_sel, m_last;
    bit m_have_prev;

    lfo_param_control #(
        .DEBOUNCE_CYC(DB), .NUM_SHAPES(NUM_SHAPES), .MAX_DEPTH(MAX_DEPTH),
        .MIN_BPM(MIN_BPM), .MAX_BPM(MAX_BPM), .FREQ_STEP(FREQ_STEP),
        .ACCEL_WINDOW(ACCEL_WINDOW)
    ) dut (
        .clk(clk), .rst(rst),
        .enc1_a(enc1_a), .enc1_b(enc1_b), .enc2_a(enc2_a), .enc2_b(enc2_b),
        .shape(shape), .depth(depth), .freq(freq), .sel(sel), .param_upd(param_upd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (param_upd === 1'b1) upd_cnt++;

    assign act_vec = {sel, shape, depth, freq};

    function automatic void model_reset();
        m_shape = 1; m_depth = 3; m_freq = 100; m_sel = 2;
        m_have_prev = 0; m_last = 0;
    endfunction

    function automatic logic [15:0] exp_vec();
        return {m_sel[1:0], m_shape[2:0], m_depth[2:0], m_freq[7:0]};
    endfunction

    function automatic int model_enc2(int dir, int t);
        int old_s = m_shape;
        int old_d = m_depth;
        int old_f = m_freq;
        int step  = FREQ_STEP;
        case (m_sel)
            0: m_shape = (m_shape + dir + NUM_SHAPES) % NUM_SHAPES;
            1: begin
                m_depth = m_depth + dir;
                if (m_depth < 0) m_depth = 0;
                if (m_depth > MAX_DEPTH) m_depth = MAX_DEPTH;
            end
            default: begin
`ifdef FREQ_ACCEL_EN
                if (m_have_prev && (t - m_last) < ACCEL_WINDOW) step = 4 * FREQ_STEP;
`endif
                m_freq = m_freq + dir * step;
                if (m_freq < MIN_BPM) m_freq = MIN_BPM;
                if (m_freq > MAX_BPM) m_freq = MAX_BPM;
            end
        endcase
        m_have_prev = 1;
        m_last = t;
        return (old_s != m_shape || old_d != m_depth || old_f != m_freq) ? 1 : 0;
    endfunction

    function automatic int model_enc1(int dir);
        m_sel = (m_sel + dir + 3) % 3;
        m_have_prev = 0;
        return 1;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pins(input bit e1, input bit e2, input logic [1:0] ab);
        if (e1) {enc1_a, enc1_b} = ab;
        if (e2) {enc2_a, enc2_b} = ab;
    endtask

    task automatic power_reset();
        @(negedge clk);
        rst = 1'b1;
        set_pins(1, 1, 2'b11);
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(DB + 10);
        model_reset();
    endtask

    // One full detent from idle 11; dir +1 walks 11->10->00->01->11
    task automatic turn(input bit e1, input bit e2, input int dir, input bit bounce,
                        output int t_done);
        logic [1:0] seq [4];
        logic [1:0] prev;
        prev = 2'b11;
        if (dir > 0) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        else         seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        t_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (bounce) begin
                repeat (20) begin
                    set_pins(e1, e2, ($urandom_range(0, 1) == 1) ? seq[i] : prev);
                    @(negedge clk);
                end
            end
            set_pins(e1, e2, seq[i]);
            if (i == 3) t_done = cyc;
            wait_cyc(HOLD);
            prev = seq[i];
        end
    endtask

    task automatic test_power_up();
        power_reset();
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL power_up_state: got %h want %h", act_vec, exp_vec());
        end
        checks++;
        if (upd_cnt !== 0) begin
            errors++;
            $display("FAIL power_up_no_upd: got %0d pulses want 0", upd_cnt);
        end
        checks++;
    endtask

    task automatic test_freq_cw();
        int u0, t, chg;
        for (int i = 0; i < 3; i++) begin
            u0 = upd_cnt;
            turn(0, 1, 1, 1, t);
            chg = model_enc2(1, t);
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL freq_cw_vec %0d: got %h want %h", i, act_vec, exp_vec());
            end
            checks++;
            if (upd_cnt - u0 !== chg) begin
                errors++;
                $display("FAIL freq_cw_upd %0d: got %0d want %0d", i, upd_cnt - u0, chg);
            end
            checks++;
        end
        if (freq !== 8'd103) begin
            errors++;
            $display("FAIL freq_cw_final: got %0d want 103", freq);
        end
        checks++;
    endtask

    task automatic test_clamp();
        int u0, t, chg;
        for (int i = 0; i < 100; i++) begin
            u0 = upd_cnt;
            turn(0, 1, -1, 0, t);
            chg = model_enc2(-1, t);
            if (act_vec !== exp_vec() || upd_cnt - u0 !== chg) begin
                errors++;
                $display("FAIL freq_ccw %0d: got %h/%0d want %h/%0d",
                         i, act_vec, upd_cnt - u0, exp_vec(), chg);
            end
            checks++;
        end
        if (freq !== 8'd20) begin
            errors++;
            $display("FAIL freq_min: got %0d want 20", freq);
        end
        checks++;
        turn(1, 0, -1, 0, t);
        chg = model_enc1(-1);
        for (int i = 0; i < 10; i++) begin
            u0 = upd_cnt;
            turn(0, 1, 1, 0, t);
            chg = model_enc2(1, t);
            if (act_vec !== exp_vec() || upd_cnt - u0 !== chg) begin
                errors++;
                $display("FAIL depth_cw %0d: got %h/%0d want %h/%0d",
                         i, act_vec, upd_cnt - u0, exp_vec(), chg);
            end
            checks++;
        end
        if (depth !== 3'd7) begin
            errors++;
            $display("FAIL depth_max: got %0d want 7", depth);
        end
        checks++;
    endtask

    task automatic test_shape_wrap();
        int t, chg;
        turn(1, 0, -1, 1, t);
        chg = model_enc1(-1);
        if (sel !== 2'd0 || act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL sel_to_shape: got %h want %h", act_vec, exp_vec());
        end
        checks++;
        for (int i = 0; i < 2; i++) begin
            turn(0, 1, -1, 0, t);
            chg = model_enc2(-1, t);
        end
        if (shape !== 3'd3 || act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL shape_wrap: got %h want %h", act_vec, exp_vec());
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        int u0, t, chg;
        power_reset();
        turn(1, 0, -1, 0, t);
        chg = model_enc1(-1);
        u0 = upd_cnt;
        turn(1, 1, 1, 0, t);
        chg = model_enc2(1, t);
        chg = model_enc1(1);
        if (depth !== 3'd4 || sel !== 2'd2 || act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL simultaneous_vec: got %h want %h", act_vec, exp_vec());
        end
        checks++;
        if (upd_cnt - u0 !== 1) begin
            errors++;
            $display("FAIL simultaneous_upd: got %0d want 1", upd_cnt - u0);
        end
        checks++;
    endtask

    task automatic test_random();
        int u0, t, chg, which, dir;
        for (int i = 0; i < 30; i++) begin
            which = $urandom_range(0, 3);
            dir   = ($urandom_range(0, 1) == 1) ? 1 : -1;
            u0 = upd_cnt;
            turn(which == 0 || which == 3, which != 0, dir, $urandom_range(0, 3) == 0, t);
            chg = 0;
            if (which != 0) chg = model_enc2(dir, t);
            if (which == 0 || which == 3) chg = model_enc1(dir);
            if (act_vec !== exp_vec() || upd_cnt - u0 !== chg) begin
                errors++;
                $display("FAIL random %0d (enc %0d dir %0d): got %h/%0d want %h/%0d",
                         i, which, dir, act_vec, upd_cnt - u0, exp_vec(), chg);
            end
            checks++;
        end
    endtask

    task automatic test_reset();
        {enc1_a, enc1_b, enc2_a, enc2_b} = 4'($urandom_range(0, 15));
        wait_cyc($urandom_range(1, 20));
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        if (act_vec !== exp_vec() || param_upd !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got %h upd %b want %h upd 0", act_vec, param_upd, exp_vec());
        end
        checks++;
        power_reset();
    endtask

    task automatic test_accel();
`ifdef FREQ_ACCEL_EN
        int t, chg;
        int exp_f [6] = '{101, 105, 109, 110, 111, 112};
        power_reset();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) wait_cyc((i < 3) ? 500 - 4 * HOLD : 5000 - 4 * HOLD);
            turn(0, 1, 1, 0, t);
            chg = model_enc2(1, t);
            if (freq !== 8'(exp_f[i]) || act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL accel %0d: got %0d want %0d", i, freq, exp_f[i]);
            end
            checks++;
        end
`endif
    endtask

    task automatic test_half_detent_reset();
        int u0;
        power_reset();
        set_pins(0, 1, 2'b10);
        wait_cyc(HOLD);
        set_pins(0, 1, 2'b00);
        wait_cyc(HOLD);
        rst = 1'b1;
        wait_cyc(4);
        rst = 1'b0;
        wait_cyc(DB + 10);
        u0 = upd_cnt;
        set_pins(0, 1, 2'b01);
        wait_cyc(HOLD);
        set_pins(0, 1, 2'b11);
        wait_cyc(HOLD);
        if (act_vec !== exp_vec() || upd_cnt - u0 !== 0) begin
            errors++;
            $display("FAIL half_detent_reset: got %h/%0d want %h/0",
                     act_vec, upd_cnt - u0, exp_vec());
        end
        checks++;
    endtask

    initial begin
        model_reset();
        test_power_up();
        test_freq_cw();
        test_clamp();
        test_shape_wrap();
        test_simultaneous();
        test_random();
        test_reset();
        test_accel();
        test_half_detent_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
